// File: rtl/bcd_scan_display_if.sv
//------------------------------------------------------------------------------
// Module   : bcd_scan_display_if
// Brief    : Digit inputs and seven-segment drive bundle for bcd_scan_display.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface bcd_scan_display_if;
  logic [3:0] ones;
  logic [3:0] tens;
  logic       run;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  modport master (output ones, tens, run, input seg, an, dp);
  modport slave  (input ones, tens, run, output seg, an, dp);
endinterface

`default_nettype wire

// File: rtl/bcd_scan_display.sv
//------------------------------------------------------------------------------
// Module   : bcd_scan_display
// Brief    : Two-digit BCD scan driver for a common-anode 4-digit display,
//            with tear-free sampling, leading-zero blanking and 00 blink.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bcd_scan_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  bcd_scan_display_if.slave  bus
);

  localparam int c_REF_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int c_BLK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [c_REF_W-1:0] c_REF_LAST = c_REF_W'(REFRESH_DIV - 1);
  localparam logic [c_BLK_W-1:0] c_BLK_LAST = c_BLK_W'(BLINK_DIV - 1);
  localparam logic [6:0] c_SEG_OFF = 7'h7F;
  localparam logic [3:0] c_AN_OFF  = 4'hF;

  logic [c_REF_W-1:0] r_ref_cnt;
  logic [c_BLK_W-1:0] r_blink_cnt;
  logic               r_sel;
  logic               r_blink_ph;
  logic [3:0]         r_ones_q;
  logic [3:0]         r_tens_q;
  logic [6:0]         r_seg;
  logic [3:0]         r_an;
  logic               r_dp;

  logic               w_ref_wrap;
  logic               w_blk_wrap;
  logic               w_zero_hold;
  logic [3:0]         w_digit;
  logic [6:0]         w_seg_nxt;
  logic [3:0]         w_an_nxt;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h3F;
    endcase
  endfunction

  assign w_ref_wrap  = (r_ref_cnt == c_REF_LAST);
  assign w_blk_wrap  = (r_blink_cnt == c_BLK_LAST);
  assign w_zero_hold = bus.run && (r_ones_q == 4'd0) && (r_tens_q == 4'd0);
  assign w_digit     = r_sel ? r_tens_q : r_ones_q;

  // Blink override beats leading-zero blanking, which beats normal decode.
  always_comb begin
    w_seg_nxt = decode(w_digit);
    w_an_nxt  = r_sel ? 4'b1101 : 4'b1110;
    if (w_zero_hold && r_blink_ph) begin
      w_seg_nxt = c_SEG_OFF;
      w_an_nxt  = c_AN_OFF;
    end else if (r_sel && BLANK_LZ && (r_tens_q == 4'd0)) begin
      w_seg_nxt = c_SEG_OFF;
      w_an_nxt  = c_AN_OFF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ref_cnt   <= '0;
      r_sel       <= 1'b0;
      r_blink_cnt <= '0;
      r_blink_ph  <= 1'b0;
      r_ones_q    <= 4'd0;
      r_tens_q    <= 4'd0;
      r_seg       <= c_SEG_OFF;
      r_an        <= c_AN_OFF;
      r_dp        <= 1'b1;
    end else begin
      r_ref_cnt <= w_ref_wrap ? '0 : r_ref_cnt + 1'b1;
      if (w_ref_wrap) begin
        r_sel <= ~r_sel;
        // Sample both digits together only at the end of a full scan.
        if (r_sel) begin
          r_ones_q <= bus.ones;
          r_tens_q <= bus.tens;
        end
      end
      r_blink_cnt <= w_blk_wrap ? '0 : r_blink_cnt + 1'b1;
      if (w_blk_wrap)
        r_blink_ph <= ~r_blink_ph;
      r_seg <= w_seg_nxt;
      r_an  <= w_an_nxt;
      r_dp  <= 1'b1;
    end
  end

  assign bus.seg = r_seg;
  assign bus.an  = r_an;
  assign bus.dp  = r_dp;

endmodule

`default_nettype wire

// File: tb/tb_bcd_scan_display.sv
//------------------------------------------------------------------------------
// Module   : tb_bcd_scan_display
// Brief    : Directed bench for bcd_scan_display, BLANK_LZ=1 and BLANK_LZ=0.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bcd_scan_display;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] ones = 4'd0;
  logic [3:0] tens = 4'd0;
  logic       run = 1'b0;
  int         checks = 0;
  int         errors = 0;

  bcd_scan_display_if if_a ();
  bcd_scan_display_if if_b ();

  assign if_a.ones = ones;
  assign if_a.tens = tens;
  assign if_a.run  = run;
  assign if_b.ones = ones;
  assign if_b.tens = tens;
  assign if_b.run  = run;

  bcd_scan_display #(.REFRESH_DIV(4), .BLINK_DIV(8), .BLANK_LZ(1'b1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a.slave)
  );

  bcd_scan_display #(.REFRESH_DIV(4), .BLINK_DIV(8), .BLANK_LZ(1'b0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b.slave)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [6:0] es, input logic [3:0] ea);
    checks++;
    assert ({if_a.seg, if_a.an, if_a.dp} === {es, ea, 1'b1}) else begin
      errors++;
      $error("FAIL %s: seg/an/dp observed %h/%h/%b expected %h/%h/1",
             tag, if_a.seg, if_a.an, if_a.dp, es, ea);
    end
  endtask

  task automatic chk_b(input string tag, input logic [6:0] es, input logic [3:0] ea);
    checks++;
    assert ({if_b.seg, if_b.an, if_b.dp} === {es, ea, 1'b1}) else begin
      errors++;
      $error("FAIL %s: seg/an/dp observed %h/%h/%b expected %h/%h/1",
             tag, if_b.seg, if_b.an, if_b.dp, es, ea);
    end
  endtask

  task automatic phase_a(input string tag, input logic [6:0] es, input logic [3:0] ea,
                         input int n);
    for (int i = 0; i < n; i++) begin
      step(1);
      chk_a(tag, es, ea);
    end
  endtask

  task automatic phase_ab(input string tag, input logic [6:0] esa, input logic [3:0] eaa,
                          input logic [6:0] esb, input logic [3:0] eab, input int n);
    for (int i = 0; i < n; i++) begin
      step(1);
      chk_a({tag, "_lz1"}, esa, eaa);
      chk_b({tag, "_lz0"}, esb, eab);
    end
  endtask

  initial begin
    // Test 1: reset, then first scan with unsampled zero digits (edges 1..16)
    ones = 4'd7; tens = 4'd4; run = 1'b0; rst = 1'b1;
    step(3);
    chk_a("reset_hold", 7'h7F, 4'hF);
    chk_b("reset_hold_b", 7'h7F, 4'hF);
    rst = 1'b0;
    phase_ab("first_ones", 7'h40, 4'hE, 7'h40, 4'hE, 4);
    phase_ab("first_tens", 7'h7F, 4'hF, 7'h40, 4'hD, 4);
    phase_a("ones_7", 7'h78, 4'hE, 4);
    phase_a("tens_4", 7'h19, 4'hD, 4);

    // Test 2: 5/0, sampled at edge 24
    ones = 4'd5; tens = 4'd0;
    phase_a("pre_ones_7", 7'h78, 4'hE, 4);
    phase_a("pre_tens_4", 7'h19, 4'hD, 4);
    phase_ab("ones_5", 7'h12, 4'hE, 7'h12, 4'hE, 4);
    phase_ab("tens_0", 7'h7F, 4'hF, 7'h40, 4'hD, 4);

    // Test 3: no tearing; 3/2 sampled at edge 40
    ones = 4'd3; tens = 4'd2;
    step(8);
    phase_a("ones_3", 7'h30, 4'hE, 4);
    ones = 4'd9; tens = 4'd8;
    phase_a("tear_tens_a", 7'h24, 4'hD, 2);
    ones = 4'd3; tens = 4'd2;
    phase_a("tear_tens_b", 7'h24, 4'hD, 2);
    phase_a("tear_ones", 7'h30, 4'hE, 4);
    ones = 4'd9; tens = 4'd8;
    phase_a("held_tens_2", 7'h24, 4'hD, 4);
    phase_a("ones_9", 7'h10, 4'hE, 4);
    phase_a("tens_8", 7'h00, 4'hD, 4);

    // Test 4: 00 with run; zero_hold from edge 73, dark while blink_ph = 1
    ones = 4'd0; tens = 4'd0; run = 1'b1;
    phase_a("pre0_ones_9", 7'h10, 4'hE, 4);
    phase_a("pre0_tens_8", 7'h00, 4'hD, 4);
    phase_a("blink_dark1", 7'h7F, 4'hF, 8);
    phase_a("blink_on_ones", 7'h40, 4'hE, 4);
    phase_a("blink_on_tens", 7'h7F, 4'hF, 4);
    phase_a("blink_dark2", 7'h7F, 4'hF, 2);
    run = 1'b0;
    phase_a("run_drop_ones", 7'h40, 4'hE, 2);
    phase_a("run_drop_tens", 7'h7F, 4'hF, 1);
    step(3);

    // Test 5: non-BCD digits show dash; sampled at edge 104
    ones = 4'hC; tens = 4'hA;
    step(8);
    phase_ab("dash_ones", 7'h3F, 4'hE, 7'h3F, 4'hE, 4);
    phase_ab("dash_tens", 7'h3F, 4'hD, 7'h3F, 4'hD, 2);

    // Test 6: reset while the tens digit is lit
    rst = 1'b1;
    step(1);
    chk_a("midscan_rst", 7'h7F, 4'hF);
    chk_b("midscan_rst_b", 7'h7F, 4'hF);
    step(1);
    chk_a("midscan_rst2", 7'h7F, 4'hF);
    rst = 1'b0;
    phase_ab("post_rst_ones", 7'h40, 4'hE, 7'h40, 4'hE, 4);
    phase_ab("post_rst_tens", 7'h7F, 4'hF, 7'h40, 4'hD, 4);
    phase_a("post_rst_dash", 7'h3F, 4'hE, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bcd_scan_display.md
Name: bcd_scan_display

Overview:
Downstream consumer of the two-digit BCD countdown (ones digit, tens digit) produced by the timer stage. Time-multiplexes both digits onto the board's 4-anode common-anode seven-segment display. Provides tear-free sampling of the digits, leading-zero blanking, and a blink indication when the countdown reaches 00 while running. All outputs are registered.

Parameters:
REFRESH_DIV, 100000, clk cycles each digit is lit before the scan advances; must be >= 2.
BLINK_DIV, 25000000, clk cycles per blink half-period; must be >= 2.
BLANK_LZ, 1, 1 = blank tens digit when it is 0; 0 = always show it.

Ports:
clk  input  1  system clock, single clock domain.
rst  input  1  synchronous, active-high reset.
ones  input  4  BCD ones digit from timer stage.
tens  input  4  BCD tens digit from timer stage.
run  input  1  countdown enabled (same switch that gates the timer).
seg  output  7  segment drive {g,f,e,d,c,b,a}, active-low.
an  output  4  anode enables, active-low; an[0] = ones, an[1] = tens, an[3:2] always 1.
dp  output  1  decimal point, active-low; held 1.

Behaviour:
- Reset (rst high at a clk edge) clears all state:
  - ref_cnt = 0, sel = 0, blink_cnt = 0, blink_ph = 0, ones_q = tens_q = 0.
  - seg = 7'h7F, an = 4'hF, dp = 1.
  - Mid-scan reset aborts immediately; no partial digit is shown on the following cycle.
- ref_cnt counts 0..REFRESH_DIV-1 and wraps to 0.
  - On the wrap cycle, sel toggles (0 = ones, 1 = tens).
- Sampling: ones_q/tens_q load from ones/tens only on the wrap cycle where sel goes 1->0, i.e. once per full scan.
  - Both digits therefore always come from the same input cycle. No tearing.
  - Input changes between sample points are ignored.
- blink_cnt counts 0..BLINK_DIV-1 and wraps; blink_ph toggles on each wrap. It runs freely regardless of run.
- zero_hold = run AND (ones_q == 0) AND (tens_q == 0).
- Decode, nibble to seg:
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19, 5 = 12, 6 = 02, 7 = 78, 8 = 00, 9 = 10 (hex).
  - Any value 10-15 displays dash = 3F.
- Output register, updated every clk after reset, one cycle latency from sel/ones_q/tens_q/blink_ph:
  - Digit selected by sel: ones_q when sel = 0, tens_q when sel = 1. Anode an[sel] = 0, all others 1.
  - seg = decode of the selected digit.
  - When sel = 1, BLANK_LZ = 1 and tens_q == 0: an = 4'hF, seg = 7'h7F.
  - When zero_hold AND blink_ph = 1: an = 4'hF, seg = 7'h7F, overriding everything else.
  - Ones digit is never leading-zero blanked.
- Never more than one anode low in any cycle.
- run falling while zero_hold is active ends blinking on the next clk; the steady 00 display resumes (tens blanked if BLANK_LZ = 1, so "0" shows).

Test Plan (REFRESH_DIV = 4, BLINK_DIV = 8 unless stated):
1. Reset hold 3 cycles, release, ones = 7, tens = 4, run = 0.
   - During reset: seg = 7F, an = F.
   - First scan (inputs not yet sampled, digits 0): ones digit shows seg = 40 on an = E for 4 cycles; tens blanked (an = F).
   - After the first sel 1->0 wrap: ones shows seg = 78 on an = E for 4 cycles, then seg = 19 on an = D for 4 cycles, repeating.
2. ones = 5, tens = 0, BLANK_LZ = 1.
   - an = E with seg = 12 for 4 cycles, then an = F with seg = 7F for 4 cycles.
   - Repeat with BLANK_LZ = 0: tens phase gives an = D, seg = 40.
3. Tearing: sampled 3/2; change inputs to 9/8 while sel = 1, then back to 3/2 before the wrap.
   - Display never shows 9 or 8, only seg = 30 and 24.
   - Change to 9/8 held through the wrap: next full scan shows seg = 10 and 00.
4. ones = 0, tens = 0, run = 1.
   - an = F whenever blink_ph = 1: 8 dark cycles alternate with 8 scanning cycles (seg = 40 on an = E).
   - Drop run during a dark phase: display resumes on the next clk.
5. ones = 4'hC, tens = 4'hA: both digits show seg = 3F (dash).
6. Assert rst mid-scan while sel = 1.
   - Next cycle: an = F, seg = 7F.
   - After release: scan restarts at ones digit with ref_cnt = 0 and sampled digits cleared to 0.
